// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 (optional even parity) UART transmitter
//
// Purpose: accepts one byte per uart_we strobe into a FIFO and serialises the
// bytes on txd as start / 8 data bits LSB first / [parity] / stop frames.
// Back-to-back frames are sent with no idle gap. Writes that arrive while the
// FIFO is full are dropped and latch the sticky overflow flag.
//
// Configuration macro: UART_TX_PARITY_EN - when defined, an even-parity bit
// follows the data bits (11-bit frame); otherwise frames are 10 bits (8N1).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   FIFO_DEPTH    byte entries (power of two, >= 2)
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   uart[7:0]  in   byte to transmit
//   uart_we    in   one-cycle write strobe
//   txd        out  serial line, idle high, driven from a flop
//   tx_busy    out  FSM not idle or FIFO not empty
//   fifo_full  out  FIFO holds FIFO_DEPTH bytes
//   overflow   out  sticky dropped-write flag, cleared only by reset

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] uart,
  input  logic       uart_we,
  output logic       txd,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        empty;
  logic        wr_en;
  logic        pop;
  logic [7:0]  head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr - rd_ptr;
  assign fifo_full = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  // Full is judged before any pop in the same cycle, so a full FIFO drops the
  // write even if the transmitter frees a slot on this edge.
  assign wr_en     = uart_we && !fifo_full;
  assign head      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (uart_we && fifo_full) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read below the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= uart;
  end

  // ---------------------------------------------------------------- FSM
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          txd_q, txd_n;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_n;
`endif

  assign bit_end = (cnt == CNT_LAST);
  assign txd     = txd_q;
  assign tx_busy = (state != S_IDLE) || !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      txd_q    <= txd_n;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

  // txd_n is the value txd will hold during the next cycle, so each bit is
  // launched on the same edge that enters its state.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    txd_n    = txd_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n = parity_q;
`endif
    case (state)
      S_IDLE: begin
        txd_n = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          shift_n  = head;
`ifdef UART_TX_PARITY_EN
          parity_n = ^head;
`endif
          txd_n    = 1'b0;
          cnt_n    = '0;
          state_n  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          txd_n   = shift[0];
          state_n = S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_n   = parity_q;
            state_n = S_PARITY;
`else
            txd_n   = 1'b1;
            state_n = S_STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
            txd_n = shift[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          txd_n   = 1'b1;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop      = 1'b1;
            shift_n  = head;
`ifdef UART_TX_PARITY_EN
            parity_n = ^head;
`endif
            txd_n    = 1'b0;
            state_n  = S_START;
          end else begin
            txd_n   = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        txd_n   = 1'b1;
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized scoreboard bench for uart_tx_fifo

module tb_uart_tx_fifo;

  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] uart;
  logic       uart_we;
  logic       txd;
  logic       tx_busy;
  logic       fifo_full;
  logic       overflow;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .uart(uart), .uart_we(uart_we),
    .txd(txd), .tx_busy(tx_busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ------------------------------------------------ reference model
  // Abstract view: a byte queue plus "cycles left in the current frame".
  logic [7:0]  mq[$];
  logic [7:0]  exp_q[$];
  int          rem = 0;
  int          start_edge = 0;
  int          ecount = 0;
  int          epoch = 0;
  logic        m_ovf = 1'b0;
  logic [10:0] fb = '1;
  logic        exp_txd;
  int          cb;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        exp_q.delete();
        rem   = 0;
        m_ovf = 1'b0;
        epoch++;
      end else begin
        ecount++;
        cb = mq.size();
        if (rem <= 1) begin
          if (cb > 0) begin
            fb         = '1;
            fb[0]      = 1'b0;
            fb[8:1]    = mq.pop_front();
`ifdef UART_TX_PARITY_EN
            fb[9]      = ^fb[8:1];
`endif
            exp_q.push_back(fb[8:1]);
            rem        = F;
            start_edge = ecount;
          end else begin
            rem = 0;
          end
        end else begin
          rem--;
        end
        if (uart_we === 1'b1) begin
          if (cb < D) mq.push_back(uart);
          else m_ovf = 1'b1;
        end
      end
      exp_txd = (rem > 0) ? fb[(ecount - start_edge) / C] : 1'b1;
      #1;
      chk("txd", {7'd0, txd}, {7'd0, exp_txd});
      chk("tx_busy", {7'd0, tx_busy}, {7'd0, (rem > 0) || (mq.size() > 0)});
      chk("fifo_full", {7'd0, fifo_full}, {7'd0, mq.size() == D});
      chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    end
  end

  // ------------------------------------------------ frame monitor
  logic [10:0] sb;
  logic [7:0]  want;
  int          e0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        e0 = epoch;
        repeat (C / 2) @(negedge clk);
        sb    = '1;
        sb[0] = txd;
        for (int i = 1; i < NB; i++) begin
          repeat (C) @(negedge clk);
          sb[i] = txd;
        end
        repeat (C - C / 2 - 1) @(negedge clk);
        if (epoch == e0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", sb[8:1], 8'h00);
            chk("unexpected_frame_count", 8'd1, 8'd0);
          end else begin
            want = exp_q.pop_front();
            chk("frame_byte", sb[8:1], want);
            chk("start_bit", {7'd0, sb[0]}, 8'd0);
            chk("stop_bit", {7'd0, sb[NB-1]}, 8'd1);
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", {7'd0, sb[9]}, {7'd0, ^want});
`endif
          end
        end
      end
    end
  end

  // ------------------------------------------------ stimulus
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    uart    = b;
    uart_we = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      uart_we = 1'b0;
    end
  endtask

  int t;

  initial begin
    uart    = 8'h00;
    uart_we = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gap(100);

    put(8'h55);
    gap(F + 10);

    put(8'hA5);
    put(8'h3C);
    gap(2 * F + 10);

    put(8'h07);
    gap(F + 10);

    for (int i = 0; i < 6; i++) put(8'(8'h11 * (i + 1)));
    gap(5 * F + 20);

    // Reset in the middle of data bit 3.
    put(8'h5A);
    gap(18);
    #2 rst_n = 1'b0;
    #1;
    chk("txd_async_reset", {7'd0, txd}, 8'd1);
    chk("busy_async_reset", {7'd0, tx_busy}, 8'd0);
    chk("ovf_async_reset", {7'd0, overflow}, 8'd0);
    gap(2);
    rst_n = 1'b1;
    gap(60);

    repeat (400) begin
      if ($urandom_range(0, 5) == 0) put(8'($urandom));
      else gap(1);
    end
    gap(1);
    t = 0;
    while (tx_busy === 1'b1 && t < 20 * D * F) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", {7'd0, tx_busy}, 8'd0);
    gap(F + 5);
    chk("frames_left_undelivered", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
